// File: rtl/pipe_elastic_if.sv
// Handshake bundle between two pipeline stages carrying a flattened stage payload.
// A beat moves on a rising edge when valid and ready are both high. Once valid is
// raised, the sender holds valid and data stable until ready is seen. Ready never
// depends combinationally on valid.
interface pipe_elastic_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline-stage buffer: DEPTH-entry circular FIFO with flush, a NOP
// bubble on empty, and a saturating count of cycles the upstream was blocked.
module pipe_elastic_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  pipe_elastic_if.slave              bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_WIDTH-1:0]       stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
    $fatal(1, "pipe_elastic_stage: DEPTH must be in 2..16");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;
  logic [CNT_WIDTH-1:0]  stall_q;
  logic                  enq;
  logic                  deq;
  logic                  blocked;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Ready comes only from the registered occupancy, so a full stage refuses
  // input even when its head leaves in the same cycle.
  assign bus.in_ready  = (cnt < CW'(DEPTH));
  assign bus.out_valid = (cnt != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : NOP_VALUE;

  assign enq     = bus.in_valid & bus.in_ready & ~flush;
  assign deq     = bus.out_valid & bus.out_ready & ~flush;
  assign blocked = bus.in_valid & ~bus.in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= next_ptr(wr_ptr);
      if (deq) rd_ptr <= next_ptr(rd_ptr);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Payload storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (blocked && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign count        = cnt;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Bench for pipe_elastic_stage: a DEPTH=2 instance driven from a vector table plus
// a saturation sequence, and a DEPTH=3 instance checked against a queue model.
module tb_pipe_elastic_stage;

  localparam logic [31:0] NOP = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT A: DEPTH=2, CNT_WIDTH=4 ----------------
  logic        rst_a, flush_a;
  logic [1:0]  count_a;
  logic [3:0]  stall_a;
  pipe_elastic_if #(.DATA_WIDTH(32)) bus_a ();

  pipe_elastic_stage #(.DATA_WIDTH(32), .DEPTH(2), .NOP_VALUE(NOP), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a), .bus(bus_a.slave),
    .count(count_a), .stall_cycles(stall_a)
  );

  // ---------------- DUT B: DEPTH=3, CNT_WIDTH=16 ----------------
  logic        rst_b, flush_b;
  logic [1:0]  count_b;
  logic [15:0] stall_b;
  pipe_elastic_if #(.DATA_WIDTH(32)) bus_b ();

  pipe_elastic_stage #(.DATA_WIDTH(32), .DEPTH(3), .NOP_VALUE(NOP), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .bus(bus_b.slave),
    .count(count_b), .stall_cycles(stall_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table for DUT A ----------------
  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] d;
    logic        e_rdy, e_vld;
    logic [31:0] e_data;
    int          e_cnt;
    int          e_stall;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic o,
                              input logic [31:0] d, input logic er, input logic ev,
                              input logic [31:0] ed, input int ec, input int es);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = o; v.d = d;
    v.e_rdy = er; v.e_vld = ev; v.e_data = ed; v.e_cnt = ec; v.e_stall = es;
    return v;
  endfunction

  // ---------------- queue reference model for DUT B ----------------
  logic [31:0] m_q[$];
  int          m_stall;
  logic [31:0] got_q[$];
  localparam int B_DEPTH = 3;

  task automatic cycle_b(input logic iv, input logic [31:0] d, input logic o, input logic fl);
    logic [31:0] exp_head;
    logic        m_rdy;
    m_rdy    = (m_q.size() < B_DEPTH);
    exp_head = (m_q.size() != 0) ? m_q[0] : NOP;
    check("b_in_ready",  32'(bus_b.in_ready),  32'(m_rdy));
    check("b_out_valid", 32'(bus_b.out_valid), 32'(m_q.size() != 0));
    check("b_out_data",  bus_b.out_data,       exp_head);
    check("b_count",     32'(count_b),         32'(m_q.size()));
    check("b_stall",     32'(stall_b),         32'(m_stall));
    bus_b.in_valid  = iv;
    bus_b.in_data   = d;
    bus_b.out_ready = o;
    flush_b         = fl;
    @(posedge clk); #1;
    if (fl) begin
      m_q.delete();
    end else begin
      if (iv && !m_rdy && m_stall < 65535) m_stall++;
      if (o && m_q.size() != 0) got_q.push_back(m_q.pop_front());
      if (iv && m_rdy) m_q.push_back(d);
    end
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; flush_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b0;
    m_q.delete();
    m_stall = 0;
  endtask

  initial begin
    rst_a = 1'b0; flush_a = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    rst_b = 1'b0; flush_b = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    m_stall = 0;

    //            rst f  iv o  data           rdy vld data          cnt stall
    vt[0]  = mk(1, 0, 0, 0, 32'h0,          1, 0, NOP,          0, 0);
    vt[1]  = mk(0, 0, 1, 1, 32'hA000_0001,  1, 1, 32'hA000_0001, 1, 0);
    vt[2]  = mk(0, 0, 0, 1, 32'h0,          1, 0, NOP,          0, 0);
    vt[3]  = mk(0, 0, 0, 0, 32'h0,          1, 0, NOP,          0, 0);
    vt[4]  = mk(0, 0, 1, 0, 32'h11,         1, 1, 32'h11,       1, 0);
    vt[5]  = mk(0, 0, 1, 0, 32'h22,         0, 1, 32'h11,       2, 0);
    vt[6]  = mk(0, 0, 1, 0, 32'h33,         0, 1, 32'h11,       2, 1);
    vt[7]  = mk(0, 0, 1, 0, 32'h33,         0, 1, 32'h11,       2, 2);
    vt[8]  = mk(0, 0, 1, 1, 32'h33,         1, 1, 32'h22,       1, 3);
    vt[9]  = mk(0, 0, 1, 1, 32'h33,         1, 1, 32'h33,       1, 3);
    vt[10] = mk(0, 0, 0, 1, 32'h0,          1, 0, NOP,          0, 3);
    vt[11] = mk(0, 0, 1, 0, 32'h44,         1, 1, 32'h44,       1, 3);
    vt[12] = mk(0, 0, 1, 0, 32'h55,         0, 1, 32'h44,       2, 3);
    vt[13] = mk(0, 0, 1, 1, 32'h66,         1, 1, 32'h55,       1, 4);
    vt[14] = mk(0, 0, 1, 0, 32'h66,         0, 1, 32'h55,       2, 4);
    vt[15] = mk(0, 1, 1, 1, 32'h77,         1, 0, NOP,          0, 4);
    vt[16] = mk(0, 0, 0, 0, 32'h0,          1, 0, NOP,          0, 4);
    vt[17] = mk(0, 0, 1, 0, 32'h88,         1, 1, 32'h88,       1, 4);
    vt[18] = mk(0, 1, 1, 0, 32'h99,         1, 0, NOP,          0, 4);
    vt[19] = mk(0, 0, 0, 1, 32'h0,          1, 0, NOP,          0, 4);
    vt[20] = mk(0, 0, 1, 0, 32'hAA,         1, 1, 32'hAA,       1, 4);
    vt[21] = mk(0, 0, 1, 0, 32'hBB,         0, 1, 32'hAA,       2, 4);
    vt[22] = mk(0, 0, 1, 0, 32'hCC,         0, 1, 32'hAA,       2, 5);
    vt[23] = mk(1, 0, 1, 1, 32'hDD,         1, 0, NOP,          0, 0);
    vt[24] = mk(0, 0, 0, 0, 32'h0,          1, 0, NOP,          0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < NV; i++) begin
      rst_a = vt[i].rst; flush_a = vt[i].flush;
      bus_a.in_valid = vt[i].iv; bus_a.out_ready = vt[i].ordy; bus_a.in_data = vt[i].d;
      @(posedge clk); #1;
      check($sformatf("a_in_ready[%0d]", i),  32'(bus_a.in_ready),  32'(vt[i].e_rdy));
      check($sformatf("a_out_valid[%0d]", i), 32'(bus_a.out_valid), 32'(vt[i].e_vld));
      check($sformatf("a_out_data[%0d]", i),  bus_a.out_data,       vt[i].e_data);
      check($sformatf("a_count[%0d]", i),     32'(count_a),         32'(vt[i].e_cnt));
      check($sformatf("a_stall[%0d]", i),     32'(stall_a),         32'(vt[i].e_stall));
    end

    // Saturation: 2 accepted beats then 20 blocked cycles into a 4-bit counter.
    rst_a = 1'b0; flush_a = 1'b0;
    bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      bus_a.in_data = 32'h100 + 32'(k);
      @(posedge clk); #1;
      if (k == 15) check("a_stall_pre_sat", 32'(stall_a), 32'd14);
    end
    check("a_stall_sat", 32'(stall_a), 32'd15);
    check("a_count_sat", 32'(count_a), 32'd2);
    check("a_head_sat",  bus_a.out_data, 32'h100);
    bus_a.in_valid = 1'b0;

    // Wrap-around: 10 sequential values into DEPTH=3 with out_ready toggling.
    reset_b();
    got_q.delete();
    begin
      int next_v = 1;
      for (int c = 0; c < 80 && got_q.size() < 10; c++) begin
        logic iv;
        iv = (next_v <= 10);
        if (iv && m_q.size() < B_DEPTH) begin
          cycle_b(1'b1, 32'(next_v), (c % 2) == 0, 1'b0);
          next_v++;
        end else begin
          cycle_b(iv, 32'(next_v), (c % 2) == 0, 1'b0);
        end
      end
    end
    check("b_wrap_count", 32'(got_q.size()), 32'd10);
    for (int k = 0; k < got_q.size() && k < 10; k++)
      check($sformatf("b_wrap_order[%0d]", k), got_q[k], 32'(k + 1));

    // Randomized traffic with occasional flush.
    reset_b();
    for (int c = 0; c < 400; c++) begin
      cycle_b($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 19) == 0);
    end
    cycle_b(1'b0, 32'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
